key_press_conditioner: RTL and testbench
========================================

Name: key_press_conditioner

Overview:
- Upstream stage for the push-button counter: conditions raw push-button KEY[1] into clean, single-cycle, clock-synchronous press events on CLOCK_50.
- Chain: 2-FF synchronizer -> debounce FSM -> press/release pulse generator -> optional auto-repeat.
- key_pulse drives the counter's increment input, replacing the ad-hoc latch/flag logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); legal range >= 1.
- REPEAT_EN, 1, 1 = auto-repeat while held; 0 = exactly one press pulse per press.
- REPEAT_DELAY, 25000000, HELD cycles before the first repeat pulse (500 ms); legal range >= 1.
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (100 ms); legal range >= 1.

Ports:
- CLOCK_50  input  1  system clock, all logic on its rising edge.
- KEY  input  2  KEY[0]: asynchronous, active-low reset. KEY[1]: raw button, active-low (0 = pressed), asynchronous to CLOCK_50.
- key_level  output  1  debounced state, 1 = pressed (high in HELD and RELEASE_DEBOUNCE).
- key_pulse  output  1  one-cycle strobe on each accepted press and each auto-repeat.
- release_pulse  output  1  one-cycle strobe on accepted release.
- repeat_active  output  1  high once auto-repeat has started, until release is accepted.

Behaviour:
- Reset: KEY[0]=0 acts immediately, with no clock. Sync flops go to 1 (released) and the FSM goes to RELEASED. Debounce and repeat counters clear. All outputs are 0. Reset mid-press aborts everything and emits no pulses.
- Synchronizer: s1 <= KEY[1]; s2 <= s1. Only s2 is used downstream.
- Counter widths: $clog2(max of the parameters)+1 bits. Counters saturate and never wrap.
- All outputs are registered. key_pulse and release_pulse are never high for 2 consecutive cycles, except that a repeat pulse with REPEAT_RATE=1 fires every cycle.
- FSM, evaluated each rising edge:
  - RELEASED: if s2=0, go to PRESS_DEBOUNCE and set dcnt=0.
  - PRESS_DEBOUNCE: if s2=1, return to RELEASED (bounce rejected, no pulse). Else if dcnt==DEBOUNCE_CYCLES-1, go to HELD, set key_pulse=1 for the next cycle, set rcnt=0. Else dcnt++.
  - HELD: if s2=1, go to RELEASE_DEBOUNCE with dcnt=0; rcnt freezes.
    - Else, if REPEAT_EN, rcnt++.
    - Repeat fires when rcnt reaches REPEAT_DELAY-1 (first repeat) or REPEAT_RATE-1 (later repeats). On a repeat: key_pulse=1, repeat_active=1, rcnt=0.
  - RELEASE_DEBOUNCE: if s2=0, return to HELD with rcnt resumed, not reset; no new press pulse. Else if dcnt==DEBOUNCE_CYCLES-1, go to RELEASED, set release_pulse=1 for one cycle, clear repeat_active. Else dcnt++.
- Latency: KEY[1] first sampled low on edge 1 and held stable makes key_pulse high during the cycle following edge DEBOUNCE_CYCLES+3. Release latency is symmetric, on release_pulse.
- Boundaries:
  - A glitch shorter than DEBOUNCE_CYCLES+1 cycles produces no output.
  - DEBOUNCE_CYCLES=1 accepts after one stable cycle in the debounce state.
  - KEY[1] held low across reset deassertion is treated as a new press after the full debounce time.
  - REPEAT_EN=0: rcnt is held at 0 and repeat_active is never set.

Test Plan:
- Params DEBOUNCE_CYCLES=4, REPEAT_EN=0: reset, then KEY[1]=0 held 20 cycles -> key_pulse high for exactly 1 cycle, after edge 7; key_level=1 from the same cycle; then KEY[1]=1 -> release_pulse one cycle, 7 edges later; key_level=0.
- Bounce: KEY[1] toggles 0/1 every 2 cycles for 30 cycles, then stays 1 -> key_pulse, release_pulse and key_level remain 0 throughout.
- Release bounce: in HELD, KEY[1]=1 for 3 cycles then 0 -> stays HELD, no release_pulse, no extra key_pulse.
- Auto-repeat with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, hold 30 cycles after first pulse -> pulses at +0, +10, +13, +16 ...; repeat_active goes 1 at +10; cleared on accepted release.
- Reset mid-operation: assert KEY[0]=0 between clock edges during HELD -> all outputs 0 immediately; release KEY[0] with KEY[1]=0 -> fresh key_pulse 7 edges later.
- Counter integration: feed key_pulse to the 4-bit counter, issue 17 clean presses -> count reads 1.

Source files
------------

// File: rtl/key_press_conditioner_if.sv
// Conditioned push-button event outputs: debounced level plus press/release/repeat strobes.
interface key_press_conditioner_if;
  logic key_level;
  logic key_pulse;
  logic release_pulse;
  logic repeat_active;

  modport master (output key_level, key_pulse, release_pulse, repeat_active);
  modport slave  (input  key_level, key_pulse, release_pulse, repeat_active);
endinterface

// File: rtl/key_press_conditioner.sv
// Turns raw active-low KEY[1] into clean CLOCK_50-synchronous press/release/repeat strobes.
// Chain: 2-FF synchronizer -> debounce FSM -> pulse generation -> optional auto-repeat.
module key_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                    CLOCK_50,
  input  logic [1:0]              KEY,
  key_press_conditioner_if.master evt
);
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CW    = $clog2(MAX_P) + 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t D_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t RD_LAST = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t RR_LAST = cnt_t'(REPEAT_RATE - 1);
  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_DEBOUNCE,
    HELD,
    RELEASE_DEBOUNCE
  } state_t;

  logic   rst_n;
  logic   s1, s2;
  state_t state;
  cnt_t   dcnt, rcnt;
  logic   level_q, kp_q, rp_q, ra_q;

  assign rst_n = KEY[0];

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_MAX) ? c : c + cnt_t'(1);
  endfunction

  // Sync flops reset to the released level so a held key after reset is seen as a new press.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= KEY[1];
      s2 <= s1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RELEASED;
      dcnt    <= '0;
      rcnt    <= '0;
      level_q <= 1'b0;
      kp_q    <= 1'b0;
      rp_q    <= 1'b0;
      ra_q    <= 1'b0;
    end else begin
      kp_q <= 1'b0;
      rp_q <= 1'b0;
      case (state)
        RELEASED: begin
          if (!s2) begin
            state <= PRESS_DEBOUNCE;
            dcnt  <= '0;
          end
        end
        PRESS_DEBOUNCE: begin
          if (s2) begin
            state <= RELEASED;
          end else if (dcnt == D_LAST) begin
            state   <= HELD;
            level_q <= 1'b1;
            kp_q    <= 1'b1;
            rcnt    <= '0;
          end else begin
            dcnt <= sat_inc(dcnt);
          end
        end
        HELD: begin
          if (s2) begin
            state <= RELEASE_DEBOUNCE;
            dcnt  <= '0;
          end else if (REPEAT_EN) begin
            // First repeat waits the long delay; once repeating, the short rate applies.
            if (rcnt == (ra_q ? RR_LAST : RD_LAST)) begin
              kp_q <= 1'b1;
              ra_q <= 1'b1;
              rcnt <= '0;
            end else begin
              rcnt <= sat_inc(rcnt);
            end
          end
        end
        RELEASE_DEBOUNCE: begin
          // Bounce back to HELD keeps rcnt so repeat cadence is not disturbed.
          if (!s2) begin
            state <= HELD;
          end else if (dcnt == D_LAST) begin
            state   <= RELEASED;
            level_q <= 1'b0;
            rp_q    <= 1'b1;
            ra_q    <= 1'b0;
            rcnt    <= '0;
          end else begin
            dcnt <= sat_inc(dcnt);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

  assign evt.key_level     = level_q;
  assign evt.key_pulse     = kp_q;
  assign evt.release_pulse = rp_q;
  assign evt.repeat_active = ra_q;
endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: two configurations (no repeat / repeat 10,3) share one key.
module tb_key_press_conditioner;
  logic       clk = 1'b0;
  logic [1:0] key;
  int         tests = 0;
  int         fails = 0;
  bit         run_chk = 1'b0;
  bit         cnt_en = 1'b0;
  logic [3:0] cnt4 = 4'd0;

  key_press_conditioner_if ifa ();
  key_press_conditioner_if ifb ();

  key_press_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0)) dut_a (
    .CLOCK_50(clk), .KEY(key), .evt(ifa));
  key_press_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1),
                          .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut_b (
    .CLOCK_50(clk), .KEY(key), .evt(ifb));

  always #5 clk = ~clk;

  // Model: level flips after D+1 consecutive edges of disagreeing synced input;
  // hold time counts only edges spent steadily held, repeats every DELAY then RATE of it.
  localparam int D = 4;
  bit m1, m2;
  bit lvl[2], e_kp[2], e_rp[2], rep[2];
  int run[2], hc[2];

  always @(posedge clk or negedge key[0]) begin
    if (!key[0]) begin
      m1 <= 1'b1; m2 <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        lvl[i] <= 0; e_kp[i] <= 0; e_rp[i] <= 0; rep[i] <= 0; run[i] <= 0; hc[i] <= 0;
      end
    end else begin
      m1 <= key[1];
      m2 <= m1;
      for (int i = 0; i < 2; i++) begin
        e_kp[i] <= 0;
        e_rp[i] <= 0;
        if ((!m2) == lvl[i]) begin
          run[i] <= 0;
          if (i == 1 && lvl[i] && run[i] == 0) begin
            if (hc[i] + 1 == (rep[i] ? 3 : 10)) begin
              e_kp[i] <= 1; rep[i] <= 1; hc[i] <= 0;
            end else hc[i] <= hc[i] + 1;
          end
        end else if (run[i] + 1 == D + 1) begin
          lvl[i] <= !lvl[i];
          run[i] <= 0;
          hc[i]  <= 0;
          if (!lvl[i]) e_kp[i] <= 1;
          else begin e_rp[i] <= 1; rep[i] <= 0; end
        end else run[i] <= run[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (run_chk) begin
    chk("model_a", {28'd0, ifa.key_level, ifa.key_pulse, ifa.release_pulse, ifa.repeat_active},
        {28'd0, lvl[0], e_kp[0], e_rp[0], rep[0]});
    chk("model_b", {28'd0, ifb.key_level, ifb.key_pulse, ifb.release_pulse, ifb.repeat_active},
        {28'd0, lvl[1], e_kp[1], e_rp[1], rep[1]});
  end

  always @(posedge clk) if (cnt_en && ifa.key_pulse) cnt4 <= cnt4 + 4'd1;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int npa, npb, bad;
    key = 2'b10;
    #1 run_chk = 1'b1;
    tick(2);
    chk("reset_a", {28'd0, ifa.key_level, ifa.key_pulse, ifa.release_pulse, ifa.repeat_active}, 0);
    chk("reset_b", {28'd0, ifb.key_level, ifb.key_pulse, ifb.release_pulse, ifb.repeat_active}, 0);
    key[0] = 1'b1;
    tick(2);

    // Clean press: pulse after edge 7, then repeats on B at +10,+13,...
    key[1] = 1'b0;
    tick(6);
    chk("press_early_a", ifa.key_pulse, 0);
    tick(1);
    chk("press_edge7_a", ifa.key_pulse, 1);
    chk("press_level_a", ifa.key_level, 1);
    chk("press_edge7_b", ifb.key_pulse, 1);
    npa = 0; npb = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      npa += int'(ifa.key_pulse);
      npb += int'(ifb.key_pulse);
      if (k == 9)  chk("rep_inactive_b", ifb.repeat_active, 0);
      if (k == 10) chk("rep_first_b", {ifb.key_pulse, ifb.repeat_active}, 2'b11);
    end
    chk("hold_pulses_a", npa, 0);
    chk("hold_pulses_b", npb, 7);
    chk("norep_active_a", ifa.repeat_active, 0);

    key[1] = 1'b1;
    tick(6);
    chk("release_early_a", ifa.release_pulse, 0);
    tick(1);
    chk("release_edge7_a", ifa.release_pulse, 1);
    chk("release_edge7_b", ifb.release_pulse, 1);
    chk("release_level_a", ifa.key_level, 0);
    chk("release_rep_b", ifb.repeat_active, 0);
    tick(1);
    chk("release_once_a", ifa.release_pulse, 0);
    tick(4);

    // Bounce every 2 cycles never survives debounce.
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      key[1] = k[0];
      for (int j = 0; j < 2; j++) begin
        tick(1);
        bad += int'(ifa.key_pulse | ifa.release_pulse | ifa.key_level);
        bad += int'(ifb.key_pulse | ifb.release_pulse | ifb.key_level);
      end
    end
    key[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      bad += int'(ifa.key_pulse | ifa.release_pulse | ifa.key_level);
    end
    chk("bounce_quiet", bad, 0);

    // Release bounce while held: stays held, no extra strobes.
    key[1] = 1'b0;
    tick(10);
    key[1] = 1'b1;
    tick(3);
    key[1] = 1'b0;
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      bad += int'(ifa.key_pulse | ifa.release_pulse | !ifa.key_level);
      bad += int'(ifb.release_pulse | !ifb.key_level);
    end
    chk("release_bounce_a", bad, 0);

    // Reset between edges while held: outputs drop at once; held key is a fresh press.
    #3 key[0] = 1'b0;
    #1;
    chk("midreset_a", {28'd0, ifa.key_level, ifa.key_pulse, ifa.release_pulse, ifa.repeat_active}, 0);
    chk("midreset_b", {28'd0, ifb.key_level, ifb.key_pulse, ifb.release_pulse, ifb.repeat_active}, 0);
    @(posedge clk); #1;
    key[0] = 1'b1;
    tick(6);
    chk("fresh_early_a", ifa.key_pulse, 0);
    tick(1);
    chk("fresh_edge7_a", ifa.key_pulse, 1);
    key[1] = 1'b1;
    tick(12);

    // 17 clean presses into a 4-bit counter wrap to 1.
    cnt_en = 1'b1;
    for (int p = 0; p < 17; p++) begin
      key[1] = 1'b0; tick(10);
      key[1] = 1'b1; tick(10);
    end
    cnt_en = 1'b0;
    chk("counter_17", cnt4, 1);

    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
